// File: rtl/cpu_sequencer.sv
// Eight-phase control sequencer for the 8-bit accumulator CPU.
// Optional trace feature (instruction counter + INST_LOAD display) under CPU_SEQ_TRACE_EN.
module cpu_sequencer #(
    parameter int unsigned MEM_WAIT   = 0,
    parameter bit          HLT_RESUME = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       resume,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
`ifdef CPU_SEQ_TRACE_EN
    ,
    output logic [15:0] instr_count
`endif
);

    localparam int unsigned WAIT_W    = 4;
    localparam int unsigned PHASE_W   = 3;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_WAIT);

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [PHASE_W-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t              phase_q, phase_d;
    logic                halted_q, halted_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                aluop;

    assign aluop = opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
            wait_q   <= '0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
            wait_q   <= wait_d;
        end
    end

    // Next-state: memory phases hold until the wait counter drains
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        wait_d   = wait_q;
        if (halted_q) begin
            if (HLT_RESUME && resume) begin
                halted_d = 1'b0;
                phase_d  = INST_ADDR;
            end
        end else begin
            unique case (phase_q)
                INST_ADDR: begin
                    phase_d = INST_FETCH;
                    wait_d  = WAIT_LOAD;
                end
                INST_FETCH: begin
                    if (wait_q == '0) phase_d = INST_LOAD;
                    else              wait_d  = wait_q - WAIT_W'(1);
                end
                INST_LOAD: phase_d = IDLE;
                IDLE:      phase_d = OP_ADDR;
                OP_ADDR: begin
                    if (opcode == OP_HLT) begin
                        halted_d = 1'b1;
                        phase_d  = INST_ADDR;
                    end else begin
                        phase_d = OP_FETCH;
                        wait_d  = WAIT_LOAD;
                    end
                end
                OP_FETCH: begin
                    if (wait_q == '0) phase_d = ALU_OP;
                    else              wait_d  = wait_q - WAIT_W'(1);
                end
                ALU_OP: phase_d = STORE;
                STORE:  phase_d = INST_ADDR;
            endcase
        end
    end

    // Strobe decode from phase, opcode and zero; halted forces everything but halt low
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        phase  = 3'd0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            phase = phase_q;
            unique case (phase_q)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: rd = aluop;
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
            endcase
        end
    end

`ifdef CPU_SEQ_TRACE_EN
    // Completed-instruction counter; halted core never reaches STORE so it freezes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (!halted_q && phase_q == STORE) begin
            instr_count <= instr_count + 16'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !halted_q && phase_q == INST_LOAD) begin
            $display("cpu_sequencer: phase=%0d opcode=%0d", phase_q, opcode);
        end
    end
`else
    // Core ports only.
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomised bench for cpu_sequencer: two instances (MEM_WAIT=0/HLT_RESUME=0 and
// MEM_WAIT=2/HLT_RESUME=1) checked every cycle against a phase/dwell model.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       resume;
    // strobe bundles: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
    logic [8:0] st0, st1;
    logic [2:0] ph0, ph1;

    int n_vec = 0;
    int n_err = 0;

    int m_phase [2];
    int m_dwell [2];
    bit m_halt  [2];
    int mw      [2] = '{0, 2};
    bit hr      [2] = '{1'b0, 1'b1};

    cpu_sequencer #(.MEM_WAIT(0), .HLT_RESUME(1'b0)) u_fast (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .resume(resume),
        .sel(st0[8]), .rd(st0[7]), .ld_ir(st0[6]), .inc_pc(st0[5]), .ld_pc(st0[4]),
        .ld_ac(st0[3]), .wr(st0[2]), .data_e(st0[1]), .halt(st0[0]), .phase(ph0)
    );

    cpu_sequencer #(.MEM_WAIT(2), .HLT_RESUME(1'b1)) u_slow (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .resume(resume),
        .sel(st1[8]), .rd(st1[7]), .ld_ir(st1[6]), .inc_pc(st1[5]), .ld_pc(st1[4]),
        .ld_ac(st1[3]), .wr(st1[2]), .data_e(st1[1]), .halt(st1[0]), .phase(ph1)
    );

    always #5 clk = ~clk;

    // Expected {phase, strobes} from the phase table
    function automatic logic [11:0] expect_out(int ph, bit halted, logic [2:0] op, logic z);
        logic [8:0] s;
        bit alu;
        if (halted) return {3'd0, 9'b0_0000_0001};
        alu  = op inside {3'd2, 3'd3, 3'd4, 3'd5};
        s[8] = (ph <= 3);
        s[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        s[6] = (ph == 2 || ph == 3);
        s[5] = (ph == 4) || (ph == 6 && op == 3'd1 && z);
        s[4] = (ph >= 6) && (op == 3'd7);
        s[3] = (ph == 7) && alu;
        s[2] = (ph == 7) && (op == 3'd6);
        s[1] = (ph >= 6) && (op == 3'd6);
        s[0] = (ph == 4) && (op == 3'd0);
        return {3'(ph), s};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0;
            m_dwell[i] = 0;
            m_halt[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        int need;
        if (!rst_n) return;
        for (int i = 0; i < 2; i++) begin
            if (m_halt[i]) begin
                if (hr[i] && resume) begin
                    m_halt[i]  = 1'b0;
                    m_phase[i] = 0;
                    m_dwell[i] = 0;
                end
            end else if (m_phase[i] == 4 && opcode == 3'd0) begin
                m_halt[i]  = 1'b1;
                m_phase[i] = 0;
                m_dwell[i] = 0;
            end else begin
                need = (m_phase[i] == 1 || m_phase[i] == 5) ? mw[i] + 1 : 1;
                m_dwell[i]++;
                if (m_dwell[i] >= need) begin
                    m_phase[i] = (m_phase[i] + 1) % 8;
                    m_dwell[i] = 0;
                end
            end
        end
    endtask

    task automatic compare();
        logic [11:0] got, want;
        for (int i = 0; i < 2; i++) begin
            got  = (i == 0) ? {ph0, st0} : {ph1, st1};
            want = expect_out(m_phase[i], m_halt[i], opcode, zero);
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL model dut%0d t=%0t op=%0d z=%0b: got ph=%0d strobes=%b, want ph=%0d strobes=%b",
                         i, $time, opcode, zero, got[11:9], got[8:0], want[11:9], want[8:0]);
            end
        end
    endtask

    task automatic check_lit(input string name, input logic [11:0] got, input logic [11:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s t=%0t: got %h, want %h", name, $time, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    // Asynchronous reset somewhere in the low half of the clock, released at a later negedge
    task automatic mid_reset();
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        model_reset();
        #1 compare();
        @(negedge clk);
        compare();
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        opcode = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        zero   = 1'($urandom_range(0, 1));
        resume = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 3'd2;
        zero   = 1'b0;
        resume = 1'b0;
        model_reset();
        @(negedge clk);
        compare();
        check_lit("reset_state", 12'({ph0, st0[8], st0[0], st0[7]}), 12'({3'd0, 1'b1, 1'b0, 1'b0}));
        rst_n = 1'b1;

        // ADD walk: fast steps one phase per cycle; slow sits 3 cycles in phases 1 and 5
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_lit("add_phase", 12'(ph0), 12'(k % 8));
            if (k == 7) check_lit("add_ld_ac", 12'({st0[7], st0[3]}), 12'(2'b11));
            if (k == 8) check_lit("slow_wait_phase5", 12'(ph1), 12'd5);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare();
        check_lit("async_reset", 12'({ph1, st1[8]}), 12'({3'd0, 1'b1}));
        @(negedge clk);
        compare();

        // HLT: halt in phase 4, then frozen; only the resumable instance leaves HALTED
        opcode = 3'd0;
        rst_n  = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        check_lit("hlt_phase4", 12'({ph0, st0[5], st0[0]}), 12'({3'd4, 2'b11}));
        for (int k = 0; k < 20; k++) tick();
        check_lit("halted_fast", 12'({ph0, st0}), 12'({3'd0, 9'b0_0000_0001}));
        check_lit("halted_slow", 12'({ph1, st1}), 12'({3'd0, 9'b0_0000_0001}));
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check_lit("resume_slow", 12'({ph1, st1[0]}), 12'd0);
        check_lit("noresume_fast", 12'(st0[0]), 12'd1);

        // SKZ taken then not taken
        mid_reset();
        opcode = 3'd1;
        zero   = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        check_lit("skz_taken", 12'({ph0, st0[5]}), 12'({3'd6, 1'b1}));
        zero = 1'b0;
        for (int k = 7; k <= 14; k++) tick();
        check_lit("skz_not_taken", 12'({ph0, st0[5]}), 12'({3'd6, 1'b0}));

        // STO then JMP
        mid_reset();
        opcode = 3'd6;
        for (int k = 1; k <= 7; k++) tick();
        check_lit("sto_phase7", 12'({ph0, st0[7], st0[2], st0[1]}), 12'({3'd7, 3'b011}));
        opcode = 3'd7;
        for (int k = 8; k <= 14; k++) tick();
        check_lit("jmp_phase6", 12'({ph0, st0[4]}), 12'({3'd6, 1'b1}));

        // Random opcodes, zero, resume and asynchronous resets
        for (int b = 0; b < 40; b++) begin
            mid_reset();
            for (int c = 0; c < 100; c++) begin
                rand_inputs();
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
